// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED event scheduler.
// The state enum is shared so the scheduler and any viewers agree on encoding.
package led_sched_pkg;

   localparam int N_EVT_DEF      = 4;
   localparam int HOLD_TICKS_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Index width for an N-entry vector; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at N_EVT-1.
// Zero latency; no flow control, found=0 when no request is present.
module led_rr_arbiter
   import led_sched_pkg::*;
#(
   parameter int N_EVT = N_EVT_DEF,
   parameter int IW    = idx_w(N_EVT)
) (
   input  logic [N_EVT-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [N_EVT-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             found
);

   always_comb begin
      int            j;
      logic [IW-1:0] jj;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      // k runs 1..N_EVT so the last granted source is considered last.
      for (int k = 1; k <= N_EVT; k++) begin
         j = int'(last) + k;
         if (j >= N_EVT) j = j - N_EVT;
         jj = IW'(j);
         if (!found && req[jj]) begin
            found   = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/led_event_sched.sv
// Latches event pulses and shows them one at a time on a one-hot LED bus, round-robin.
// Optional blinking of the shown LED is enabled by defining LED_SCHED_BLINK_EN.
module led_event_sched
   import led_sched_pkg::*;
#(
   parameter int N_EVT      = N_EVT_DEF,
   parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             tick,
   input  logic [N_EVT-1:0] evt_in,
   output logic [N_EVT-1:0] led_out,
   output logic [N_EVT-1:0] pending,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   localparam int            IW        = idx_w(N_EVT);
   localparam logic [IW-1:0] PTR_RST   = IW'(N_EVT - 1);
   localparam logic [3:0]    HOLD_INIT = 4'(HOLD_TICKS);

   state_t           state;
   logic [3:0]       hold_cnt;
   logic [IW-1:0]    rr_ptr;
   logic [N_EVT-1:0] show_vec;

   logic [N_EVT-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_found;

   logic             grant;
   logic [N_EVT-1:0] clr_vec;
   logic [N_EVT-1:0] coal_vec;
   logic [3:0]       coal_num;
   logic [8:0]       drop_sum;

   led_rr_arbiter #(
      .N_EVT (N_EVT),
      .IW    (IW)
   ) u_arb (
      .req   (pending),
      .last  (rr_ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .found (arb_found)
   );

   assign grant   = (state == IDLE) && arb_found;
   assign clr_vec = grant ? arb_gnt : '0;
   // A new pulse on the source being granted re-arms it rather than counting as a drop.
   assign coal_vec = evt_in & pending & ~clr_vec;

   always_comb begin
      coal_num = '0;
      for (int i = 0; i < N_EVT; i++) begin
         coal_num = coal_num + 4'(coal_vec[i]);
      end
   end

   assign drop_sum = {1'b0, drop_cnt} + 9'(coal_num);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending  <= '0;
         drop_cnt <= '0;
      end else begin
         pending  <= (pending & ~clr_vec) | evt_in;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state    <= IDLE;
         led_out  <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         rr_ptr   <= PTR_RST;
         show_vec <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state    <= SHOW;
                  led_out  <= arb_gnt;
                  show_vec <= arb_gnt;
                  rr_ptr   <= arb_idx;
                  hold_cnt <= HOLD_INIT;
                  busy     <= 1'b1;
               end
            end
            SHOW: begin
               if (tick) begin
                  if (hold_cnt <= 4'd1) begin
                     state    <= GAP;
                     led_out  <= '0;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt - 4'd1;
`ifdef LED_SCHED_BLINK_EN
                     led_out  <= (|led_out) ? '0 : show_vec;
`else
                     led_out  <= show_vec;
`endif
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               led_out <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_event_sched.sv
// Bench for led_event_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_led_event_sched;

   localparam int N = 4;
   localparam int H = 2;
`ifdef LED_SCHED_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resetN;
   logic         tick;
   logic [N-1:0] evt_in;
   logic [N-1:0] led_out;
   logic [N-1:0] pending;
   logic         busy;
   logic [7:0]   drop_cnt;

   always #5 clk = ~clk;

   led_event_sched #(.N_EVT(N), .HOLD_TICKS(H)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .tick     (tick),
      .evt_in   (evt_in),
      .led_out  (led_out),
      .pending  (pending),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: which sources wait, which one is shown, how many ticks remain.
   bit m_pend [N];
   int m_drop, m_last, m_phase, m_left, m_cur;
   bit m_on;

   function automatic logic [N-1:0] m_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic logic [N-1:0] m_led();
      logic [N-1:0] v;
      v = '0;
      if (m_phase == 1 && m_on) v[m_cur] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_drop = 0; m_last = N - 1; m_phase = 0; m_left = 0; m_cur = 0; m_on = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] e, input logic t);
      int g;
      g = -1;
      if (m_phase == 0)
         for (int k = 1; k <= N; k++)
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      for (int i = 0; i < N; i++) begin
         if (e[i] && m_pend[i] && i != g) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
         m_pend[i] = (m_pend[i] && i != g) || e[i];
      end
      if (m_phase == 0) begin
         if (g >= 0) begin m_phase = 1; m_left = H; m_cur = g; m_last = g; m_on = 1'b1; end
      end else if (m_phase == 1) begin
         if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
            else if (BLINK) m_on = !m_on;
         end
      end else if (t) begin
         m_phase = 0;
      end
   endtask

   task automatic step(input logic [N-1:0] e, input logic t);
      evt_in = e;
      tick   = t;
      @(posedge clk);
      model_step(e, t);
      #1;
      evt_in = '0;
      tick   = 1'b0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      evt_in = '0;
      tick   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (led_out !== '0) $display("FAIL reset_led got=%b exp=0000", led_out); else n_pass++;
      n_checks++; if (pending !== '0) $display("FAIL reset_pending got=%b exp=0000", pending); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      step(4'b0001, 1'b0);
      n_checks++; if (pending !== 4'b0001) $display("FAIL single_pend got=%b exp=0001", pending); else n_pass++;
      n_checks++; if (led_out !== 4'b0000) $display("FAIL single_early got=%b exp=0000", led_out); else n_pass++;
      step('0, 1'b0);
      n_checks++; if (led_out !== 4'b0001) $display("FAIL single_latency got=%b exp=0001", led_out); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else n_pass++;
      step('0, 1'b1);
      n_checks++; if (led_out !== m_led()) $display("FAIL single_tick1 got=%b exp=%b", led_out, m_led()); else n_pass++;
      step('0, 1'b0); step('0, 1'b0);
      step('0, 1'b1);
      n_checks++; if (led_out !== 4'b0000) $display("FAIL single_off got=%b exp=0000", led_out); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_gap_busy got=%b exp=1", busy); else n_pass++;
      step('0, 1'b0); step('0, 1'b0);
      step('0, 1'b1);
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] seq[$];
      logic [N-1:0] prev;
      logic [N-1:0] want;
      do_reset();
      prev = '0;
      step(4'b1111, 1'b0);
      for (int c = 0; c < 200 && !(seq.size() == 4 && busy === 1'b0); c++) begin
         step('0, (c % 3) == 2);
         if (prev == '0 && led_out != '0) seq.push_back(led_out);
         prev = led_out;
      end
      n_checks++; if (seq.size() != 4) $display("FAIL rr_count got=%0d exp=4", seq.size()); else n_pass++;
      for (int i = 0; i < 4 && i < seq.size(); i++) begin
         want = '0; want[i] = 1'b1;
         n_checks++; if (seq[i] !== want) $display("FAIL rr_order[%0d] got=%b exp=%b", i, seq[i], want); else n_pass++;
      end
      n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rr_drop got=%0d exp=0", drop_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rr_timeout busy=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_coalesce();
      int shows;
      logic [N-1:0] prev;
      do_reset();
      step(4'b0001, 1'b0); step('0, 1'b0);
      step(4'b0100, 1'b0);
      repeat (4) step('0, 1'b0);
      step(4'b0100, 1'b0);
      n_checks++; if (drop_cnt !== 8'd1) $display("FAIL coal_drop got=%0d exp=1", drop_cnt); else n_pass++;
      n_checks++; if (pending !== 4'b0100) $display("FAIL coal_pend got=%b exp=0100", pending); else n_pass++;
      shows = 0; prev = led_out;
      for (int c = 0; c < 200; c++) begin
         step('0, (c % 3) == 2);
         if (prev != 4'b0100 && led_out == 4'b0100) shows++;
         prev = led_out;
      end
      n_checks++; if (shows != 1) $display("FAIL coal_shows got=%0d exp=1", shows); else n_pass++;
      step(4'b0001, 1'b0); step('0, 1'b0);
      repeat (300) step(4'b0100, 1'b0);
      n_checks++; if (drop_cnt !== 8'd255) $display("FAIL coal_sat got=%0d exp=255", drop_cnt); else n_pass++;
      step(4'b0101, 1'b0);
      n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL coal_sat_hold got=%0d exp=%0d", drop_cnt, m_drop); else n_pass++;
   endtask

   task automatic test_grant_race();
      int shows;
      logic [N-1:0] prev;
      do_reset();
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      n_checks++; if (pending !== 4'b0010) $display("FAIL race_pend got=%b exp=0010", pending); else n_pass++;
      n_checks++; if (led_out !== 4'b0010) $display("FAIL race_led got=%b exp=0010", led_out); else n_pass++;
      n_checks++; if (drop_cnt !== 8'd0) $display("FAIL race_drop got=%0d exp=0", drop_cnt); else n_pass++;
      shows = 1; prev = led_out;
      for (int c = 0; c < 200; c++) begin
         step('0, (c % 3) == 2);
         if (prev != 4'b0010 && led_out == 4'b0010) shows++;
         prev = led_out;
      end
      n_checks++; if (shows != 2) $display("FAIL race_shows got=%0d exp=2", shows); else n_pass++;
   endtask

   task automatic test_reset_mid_show();
      do_reset();
      step(4'b1000, 1'b0); step('0, 1'b0);
      step(4'b0011, 1'b0);
      n_checks++; if (led_out !== 4'b1000) $display("FAIL rst_pre_led got=%b exp=1000", led_out); else n_pass++;
      n_checks++; if (pending !== 4'b0011) $display("FAIL rst_pre_pend got=%b exp=0011", pending); else n_pass++;
      #2;
      resetN = 1'b0;
      model_reset();
      #1;
      n_checks++; if ({led_out, pending, busy, drop_cnt} !== '0)
         $display("FAIL rst_async led=%b pend=%b busy=%b drop=%0d exp all zero", led_out, pending, busy, drop_cnt);
      else n_pass++;
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      #1;
      step(4'b1111, 1'b0); step('0, 1'b0);
      n_checks++; if (led_out !== 4'b0001) $display("FAIL rst_first_grant got=%b exp=0001", led_out); else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] e;
      logic         t;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         e = N'($urandom & $urandom & $urandom);
         if (c % 500 > 400) e = N'($urandom);
         t = ($urandom_range(0, 3) == 0);
         step(e, t);
         n_checks++; if (led_out !== m_led()) $display("FAIL rnd_led c=%0d got=%b exp=%b", c, led_out, m_led()); else n_pass++;
         n_checks++; if (pending !== m_pend_vec()) $display("FAIL rnd_pend c=%0d got=%b exp=%b", c, pending, m_pend_vec()); else n_pass++;
         n_checks++; if (busy !== (m_phase != 0)) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_phase != 0); else n_pass++;
         n_checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); else n_pass++;
      end
   endtask

   initial begin
      resetN = 1'b0;
      tick   = 1'b0;
      evt_in = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_coalesce();
      test_grant_race();
      test_reset_mid_show();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/led_event_sched.md
LED_EVENT_SCHED -- requirements
Module: led_event_sched

Interface
REQ-001 SHALL have parameter N_EVT, default 4, number of event sources/LEDs (2..8).
REQ-002 SHALL have parameter HOLD_TICKS, default 2, tick pulses each granted event is displayed (1..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick  input  1  one-cycle pulse, synchronous to clk, one per second.
REQ-006 SHALL have port evt_in  input  N_EVT  per-source event pulses, synchronous to clk.
REQ-007 SHALL have port led_out  output  N_EVT  LED drive, at most one bit set.
REQ-008 SHALL have port pending  output  N_EVT  latched, not-yet-displayed events.
REQ-009 SHALL have port busy  output  1  high in SHOW or GAP.
REQ-010 SHALL have port drop_cnt  output  8  saturating count of coalesced events.

Function
REQ-011 evt_in[i]=1 SHALL set pending[i] at the next clk edge.
REQ-012 evt_in[i]=1 while pending[i]=1 SHALL leave pending[i]=1 and increment drop_cnt, saturating at 255.
REQ-013 Several evt_in bits in one cycle SHALL each be handled independently per REQ-011/012; drop_cnt adds the count of coalesced bits, saturating.
REQ-014 FSM states SHALL be IDLE, SHOW, GAP.
REQ-015 IDLE with pending!=0 SHALL go to SHOW at the next edge, grant one source by round-robin, and clear that source's pending bit.
REQ-016 Round-robin SHALL search upward from last granted index+1, wrapping at N_EVT-1; after reset the search starts at index 0.
REQ-017 evt_in[g] in the same cycle its pending bit is cleared by grant SHALL win: pending[g] stays 1 and drop_cnt is unchanged.
REQ-018 SHOW SHALL drive led_out one-hot on the granted index and load hold counter = HOLD_TICKS on entry; a tick in the entry cycle is not counted.
REQ-019 SHOW SHALL decrement on each tick and go to GAP at the edge after the HOLD_TICKS-th tick.
REQ-020 GAP SHALL drive led_out=0 and go to IDLE at the edge after the next tick.
REQ-021 Latency: an event arriving in IDLE with pending=0 SHALL light led_out two clk edges after the evt_in cycle.
REQ-022 Events for the currently displayed source SHALL set pending normally (redisplayed later).
REQ-023 led_out, busy and drop_cnt SHALL be registered outputs; pending is the register itself.

Reset
REQ-024 resetN=0 SHALL immediately force state=IDLE, led_out=0, pending=0, busy=0, drop_cnt=0, hold counter=0, RR pointer to index N_EVT-1 (next search starts at 0).
REQ-025 Reset mid-SHOW SHALL discard the granted event and all pending events.

Configuration
REQ-026 With LED_SCHED_BLINK_EN defined, the granted LED in SHOW SHALL be on in the first tick interval and toggle on every counted tick.
REQ-027 Without LED_SCHED_BLINK_EN, the granted LED SHALL be steady on throughout SHOW.

Structure
REQ-028 Package led_sched_pkg SHALL hold the FSM state enum typedef and default constants for N_EVT and HOLD_TICKS.
REQ-029 Round-robin selection SHALL be a sub-module led_rr_arbiter (request vector plus last-grant index in; one-hot grant and index out; combinational).
REQ-030 led_event_sched SHALL own the pending register, counters, RR pointer register and FSM.

Verification
REQ-031 Single event: evt_in=0001 at cycle 10 -> led_out=0001 from cycle 12; after 2 ticks led_out=0000; IDLE after one more tick.
REQ-032 Round-robin: evt_in=1111 in one cycle -> display order 0001, 0010, 0100, 1000; drop_cnt=0.
REQ-033 Coalesce: two evt_in=0100 pulses 5 cycles apart, both before grant -> one display and drop_cnt=1; 300 repeats -> drop_cnt=255.
REQ-034 Grant race: evt_in=0010 in the grant cycle of source 1 -> pending=0010 afterwards; source 1 is displayed twice.
REQ-035 Reset mid-SHOW: resetN=0 while led_out=1000 and pending=0011 -> all outputs 0 at once; first grant after reset is source 0.
REQ-036 With LED_SCHED_BLINK_EN and HOLD_TICKS=3 -> granted LED on, off, on across the three tick intervals; without it -> steady on.
